// File: rtl/disp_pkg.sv
// Shared constants and scan-state type for the 4-digit binary display scanner.
// Segment patterns are a..g on bits 0..6, active-high.
package disp_pkg;

   typedef enum logic [1:0] {
      StDig0 = 2'd0,
      StDig1 = 2'd1,
      StDig2 = 2'd2,
      StDig3 = 2'd3
   } scan_state_t;

   localparam logic [6:0] SEG_ZERO  = 7'b0111111;
   localparam logic [6:0] SEG_ONE   = 7'b0000110;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [3:0] digit_onehot(input scan_state_t st);
      logic [3:0] oh;
      oh = 4'b0001;
      unique case (st)
         StDig0:  oh = 4'b0001;
         StDig1:  oh = 4'b0010;
         StDig2:  oh = 4'b0100;
         StDig3:  oh = 4'b1000;
         default: oh = 4'b0001;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/disp_scan4_if.sv
// Capture handshake between the upstream code converter and the display scanner.
// master = upstream converter, slave = disp_scan4.
interface disp_scan4_if;
   logic       ready;
   logic [3:0] s;
   logic       ack;

   modport master (
      output ready,
      output s,
      input  ack
   );

   modport slave (
      input  ready,
      input  s,
      output ack
   );
endinterface

// File: rtl/seg_bit_enc.sv
// Combinational 1-bit value to seven-segment encoder ("0" or "1"), with blanking.
module seg_bit_enc
   import disp_pkg::*;
(
   input  logic       val,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_ZERO;
      if (blank) begin
         seg = SEG_BLANK;
      end else if (val) begin
         seg = SEG_ONE;
      end
   end

endmodule

// File: rtl/disp_scan4.sv
// Four-digit multiplexed binary display scanner with frame-synchronous word update.
// Optional macro DISP_SCAN4_BLANK_EN blanks segments from reset until the first word is shown.
module disp_scan4
   import disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   disp_scan4_if.slave  bus,
   output logic [6:0]   seg,
   output logic [3:0]   an
);

   localparam int unsigned CntW = $clog2(SCAN_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

`ifdef DISP_SCAN4_BLANK_EN
   localparam logic [6:0] SegReset = SEG_BLANK;
`else
   localparam logic [6:0] SegReset = SEG_ZERO;
`endif

   logic [CntW-1:0] cnt_q, cnt_d;
   scan_state_t     state_q, state_d;
   logic [3:0]      pend_q, pend_d;
   logic [3:0]      disp_q, disp_d;
   logic            ack_q, ack_d;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            tc;
   logic            boundary;
   logic            cur_bit;
   logic            blank_nxt;

   // Scan FSM and prescaler state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StDig0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      tc       = (cnt_q == CntMax);
      boundary = tc && (state_q == StDig3);
      cnt_d    = tc ? '0 : cnt_q + 1'b1;
      state_d  = state_q;
      if (tc) begin
         unique case (state_q)
            StDig0:  state_d = StDig1;
            StDig1:  state_d = StDig2;
            StDig2:  state_d = StDig3;
            StDig3:  state_d = StDig0;
            default: state_d = StDig0;
         endcase
      end
   end

   // pend_d already carries a word captured this cycle, so the boundary load
   // naturally bypasses P when capture and frame end coincide.
   always_comb begin
      pend_d  = bus.ready ? bus.s : pend_q;
      ack_d   = bus.ready;
      disp_d  = boundary ? pend_d : disp_q;
      an_d    = digit_onehot(state_d);
      cur_bit = disp_d[state_d];
   end

`ifdef DISP_SCAN4_BLANK_EN
   logic blank_q, blank_d;
   logic seen_q, seen_d;

   always_comb begin
      seen_d  = seen_q | bus.ready;
      blank_d = blank_q & ~(boundary & seen_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blank_q <= 1'b1;
         seen_q  <= 1'b0;
      end else begin
         blank_q <= blank_d;
         seen_q  <= seen_d;
      end
   end

   assign blank_nxt = blank_d;
`else
   assign blank_nxt = 1'b0;
`endif

   seg_bit_enc u_enc (
      .val   (cur_bit),
      .blank (blank_nxt),
      .seg   (seg_d)
   );

   // Outputs registered from the same next-state so an and seg move together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= 4'b0000;
         disp_q <= 4'b0000;
         ack_q  <= 1'b0;
         an_q   <= 4'b0001;
         seg_q  <= SegReset;
      end else begin
         pend_q <= pend_d;
         disp_q <= disp_d;
         ack_q  <= ack_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign bus.ack = ack_q;
   assign an      = an_q;
   assign seg     = seg_q;

endmodule

// File: tb/tb_disp_scan4.sv
// Scoreboard bench for disp_scan4 (SCAN_DIV=4): per-cycle expected an/seg/ack queued on drive.
// Honours DISP_SCAN4_BLANK_EN when the design is built with it.
module tb_disp_scan4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] seg;
   logic [3:0] an;

   disp_scan4_if bus ();

   disp_scan4 #(
      .SCAN_DIV (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .seg   (seg),
      .an    (an)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       ack;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;

   // Reference model state
   logic [3:0] m_disp;
   logic [3:0] m_next;
   logic       m_ack_pend;
   logic       m_blank;
   logic       m_seen;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic b);
`ifdef DISP_SCAN4_BLANK_EN
      if (m_blank) return 7'b0000000;
`endif
      return b ? 7'b0000110 : 7'b0111111;
   endfunction

   task automatic model_reset();
      m_disp     = 4'b0000;
      m_next     = 4'b0000;
      m_ack_pend = 1'b0;
      m_blank    = 1'b1;
      m_seen     = 1'b0;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check_val("an", 32'(an), 32'(mon_e.an));
         check_val("seg", 32'(seg), 32'(mon_e.seg));
         check_val("ack", 32'(bus.ack), 32'(mon_e.ack));
      end
   end

   // Drive ncyc cycles of a frame; up to two captures at frame cycles c0/c1 (-1 = none).
   task automatic run_frame(input int ncyc, input int c0, input logic [3:0] s0,
                            input int c1, input logic [3:0] s1);
      exp_t e;
      logic rdy;
      for (int i = 0; i < ncyc; i++) begin
         rdy       = (i == c0) || (i == c1);
         bus.ready = rdy;
         bus.s     = (i == c0) ? s0 : (i == c1) ? s1 : 4'($urandom);
         e.an      = 4'b0001 << (i / 4);
         e.seg     = exp_seg(m_disp[i/4]);
         e.ack     = m_ack_pend;
         exp_q.push_back(e);
         m_ack_pend = rdy;
         if (rdy) begin
            m_next = bus.s;
            m_seen = 1'b1;
         end
         if (i == 15) begin
            m_disp = m_next;
            if (m_seen) m_blank = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      bus.ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ready = 1'b0;
      bus.s     = 4'b0000;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      run_frame(16, -1, 4'b0000, -1, 4'b0000);   // idle scan
      run_frame(16, 5, 4'b1010, -1, 4'b0000);    // capture mid-DIG1
      run_frame(16, 2, 4'b0001, 3, 4'b1111);     // back-to-back, last wins
      run_frame(16, 15, 4'b0110, -1, 4'b0000);   // capture on boundary
      run_frame(16, 4, 4'b1111, -1, 4'b0000);
      run_frame(10, 9, 4'b0101, -1, 4'b0000);    // ends mid-DIG2, capture in flight

      check_val("pre_rst_an", 32'(an), 32'(4'b0100));
      check_val("pre_rst_ack", 32'(bus.ack), 32'(1'b1));
      check_val("pre_rst_seg", 32'(seg), 32'(exp_seg(1'b1)));
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_val("rst_an", 32'(an), 32'(4'b0001));
      check_val("rst_ack", 32'(bus.ack), 32'(1'b0));
      check_val("rst_seg", 32'(seg), 32'(exp_seg(1'b0)));
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_hold_an", 32'(an), 32'(4'b0001));
      reset = 1'b1;

      run_frame(16, -1, 4'b0000, -1, 4'b0000);   // discarded words stay gone
      run_frame(16, -1, 4'b0000, -1, 4'b0000);

      check_val("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
